acq_sequencer: RTL and testbench

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

---
 rtl/acq_seq_pkg.sv | 16 +
 rtl/acq_timeout_counter.sv | 30 +++
 rtl/acq_sequencer.sv | 148 ++++++++++++++
 tb/tb_acq_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_seq_pkg.sv
// Shared types and default widths for the acquisition sequencer.
package acq_seq_pkg;

  localparam int unsigned BRAM_WIDTH_DEF    = 13;
  localparam int unsigned NACQ_WIDTH_DEF    = 16;
  localparam int unsigned TIMEOUT_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARM        = 3'd1,
    ST_WAIT_BUSY  = 3'd2,
    ST_WAIT_READY = 3'd3,
    ST_NEXT       = 3'd4
  } acq_state_e;

endpackage

// File: rtl/acq_timeout_counter.sv
// Wait-phase cycle counter; expired flags the cycle on which the limit-th wait
// cycle elapses (limit of 0 never expires).
module acq_timeout_counter #(
  parameter int unsigned WIDTH = acq_seq_pkg::TIMEOUT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q;

  // Saturating so a disabled (zero) limit can run indefinitely.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  // cnt_q holds the wait cycles already completed, so the current cycle is cnt_q+1.
  assign expired = enable && (limit != '0) && (cnt_q == (limit - WIDTH'(1)));

endmodule

// File: rtl/acq_sequencer.sv
// Sequences n_acq BRAM acquisitions: restart the write-enable generator, wait for
// it to go busy then ready again, and repeat; supports abort and a live timeout.
module acq_sequencer
  import acq_seq_pkg::*;
#(
  parameter int unsigned BRAM_WIDTH    = BRAM_WIDTH_DEF,
  parameter int unsigned NACQ_WIDTH    = NACQ_WIDTH_DEF,
  parameter int unsigned TIMEOUT_WIDTH = TIMEOUT_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NACQ_WIDTH-1:0]    n_acq,
  input  logic [BRAM_WIDTH-1:0]    count_max_in,
  input  logic [TIMEOUT_WIDTH-1:0] timeout,
  input  logic                     wr_ready,
  output logic                     restart,
  output logic [BRAM_WIDTH-1:0]    count_max,
  output logic [NACQ_WIDTH-1:0]    acq_index,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic                     timed_out
);

  acq_state_e state_q, state_d;

  logic [NACQ_WIDTH-1:0] n_lat_q, n_lat_d;
  logic [NACQ_WIDTH-1:0] acq_index_d;
  logic [BRAM_WIDTH-1:0] count_max_d;
  logic                  restart_d, done_d, aborted_d, timed_out_d, busy_d;
  logic                  tmo_clear, tmo_enable, tmo_expired;

  acq_timeout_counter #(
    .WIDTH (TIMEOUT_WIDTH)
  ) u_tmo (
    .clk     (clk),
    .aresetn (aresetn),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .limit   (timeout),
    .expired (tmo_expired)
  );

  // Next state and next output values; abort overrides every other decision.
  always_comb begin
    state_d     = state_q;
    n_lat_d     = n_lat_q;
    acq_index_d = acq_index;
    count_max_d = count_max;
    aborted_d   = aborted;
    timed_out_d = timed_out;
    done_d      = 1'b0;
    tmo_clear   = 1'b0;
    tmo_enable  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort && (n_acq != '0)) begin
          state_d     = ST_ARM;
          n_lat_d     = n_acq;
          count_max_d = count_max_in;
          acq_index_d = '0;
          aborted_d   = 1'b0;
          timed_out_d = 1'b0;
        end
      end
      ST_ARM: begin
        tmo_clear = 1'b1;
        state_d   = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        tmo_enable = 1'b1;
        if (tmo_expired) begin
          state_d     = ST_IDLE;
          timed_out_d = 1'b1;
        end else if (!wr_ready) begin
          state_d = ST_WAIT_READY;
        end
      end
      ST_WAIT_READY: begin
        tmo_enable = 1'b1;
        if (tmo_expired) begin
          state_d     = ST_IDLE;
          timed_out_d = 1'b1;
        end else if (wr_ready) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        acq_index_d = acq_index + NACQ_WIDTH'(1);
        if (acq_index_d == n_lat_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ARM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      aborted_d   = 1'b1;
      done_d      = 1'b0;
      timed_out_d = timed_out;
      acq_index_d = acq_index;
    end

    restart_d = (state_d == ST_ARM);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs track the state they describe.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      n_lat_q   <= '0;
      acq_index <= '0;
      count_max <= '0;
      restart   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      n_lat_q   <= n_lat_d;
      acq_index <= acq_index_d;
      count_max <= count_max_d;
      restart   <= restart_d;
      busy      <= busy_d;
      done      <= done_d;
      aborted   <= aborted_d;
      timed_out <= timed_out_d;
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboard bench for acq_sequencer: runs are planned at the level of
// "which restarts happen and how the run ends", and a monitor checks them.
module tb_acq_sequencer;

  localparam int unsigned BW = 13;
  localparam int unsigned NW = 16;
  localparam int unsigned TW = 32;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          start;
  logic          abort;
  logic [NW-1:0] n_acq;
  logic [BW-1:0] count_max_in;
  logic [TW-1:0] timeout;
  logic          wr_ready;
  logic          restart;
  logic [BW-1:0] count_max;
  logic [NW-1:0] acq_index;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          timed_out;

  acq_sequencer #(
    .BRAM_WIDTH    (BW),
    .NACQ_WIDTH    (NW),
    .TIMEOUT_WIDTH (TW)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .start        (start),
    .abort        (abort),
    .n_acq        (n_acq),
    .count_max_in (count_max_in),
    .timeout      (timeout),
    .wr_ready     (wr_ready),
    .restart      (restart),
    .count_max    (count_max),
    .acq_index    (acq_index),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .timed_out    (timed_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit done;
    bit ab;
    bit to;
    int idx;
    int cm;
  } end_t;

  int   exp_rst_idx[$];
  int   exp_rst_cm[$];
  end_t exp_end[$];
  int   exp_done  = 0;
  int   done_seen = 0;

  int gen_t     = -1;
  int gen_len   = 120;
  bit gen_stuck = 1'b0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Reference plan: kind 0 = completes, 1 = aborted in acquisition a, 2 = timed out in acquisition a.
  function automatic void plan(int n, int cm, int kind, int a);
    int   nr;
    end_t e;
    nr = (kind == 0) ? n : a;
    for (int i = 0; i < nr; i++) begin
      exp_rst_idx.push_back(i);
      exp_rst_cm.push_back(cm);
    end
    e.done = (kind == 0);
    e.ab   = (kind == 1);
    e.to   = (kind == 2);
    e.idx  = (kind == 0) ? n : a - 1;
    e.cm   = cm;
    exp_end.push_back(e);
    if (kind == 0) exp_done++;
  endfunction

  // Write-enable generator model: drops ready the cycle after restart, raises it gen_len cycles later.
  always @(negedge clk) begin
    if (!aresetn) begin
      gen_t    = -1;
      wr_ready = 1'b1;
    end else begin
      if (restart) gen_t = 0;
      else if (!busy) gen_t = -1;
      else if (gen_t >= 0 && gen_t < 1000000) gen_t++;
      if (gen_t < 1) wr_ready = 1'b1;
      else if (gen_stuck) wr_ready = 1'b0;
      else wr_ready = (gen_t > gen_len);
    end
  end

  // Monitor: every restart pulse and every end of run is checked against the plan.
  bit   busy_prev = 1'b0;
  end_t me;
  always @(negedge clk) begin
    if (!aresetn) begin
      busy_prev = 1'b0;
    end else begin
      if (done) done_seen++;
      if (restart) begin
        chk("restart_expected", int'(exp_rst_idx.size() != 0), 1);
        if (exp_rst_idx.size() != 0) begin
          chk("restart_idx", int'(acq_index), exp_rst_idx.pop_front());
          chk("restart_cm", int'(count_max), exp_rst_cm.pop_front());
        end
      end
      if (busy_prev && !busy) begin
        chk("end_expected", int'(exp_end.size() != 0), 1);
        if (exp_end.size() != 0) begin
          me = exp_end.pop_front();
          chk("end_done", int'(done), int'(me.done));
          chk("end_aborted", int'(aborted), int'(me.ab));
          chk("end_timed_out", int'(timed_out), int'(me.to));
          chk("end_idx", int'(acq_index), me.idx);
          chk("end_cm", int'(count_max), me.cm);
        end
      end
      busy_prev = busy;
    end
  end

  // Returns on the negedge where the accepted run's first restart is visible.
  task automatic do_start(int n, int cm, int to);
    n_acq        = NW'(n);
    count_max_in = BW'(cm);
    timeout      = TW'(to);
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    n_acq        = NW'($urandom);
    count_max_in = BW'($urandom);
  endtask

  task automatic wait_restarts(int m);
    int c = 0;
    int t = 0;
    while (c < m && t < 5000) begin
      @(negedge clk);
      t++;
      if (restart) c++;
    end
    if (c < m) chk("restart_wait", c, m);
  endtask

  task automatic wait_idle(int budget);
    int t = 0;
    while (busy && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("run_finishes", int'(busy), 0);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_restart"}, int'(restart), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_aborted"}, int'(aborted), 0);
    chk({tag, "_timed_out"}, int'(timed_out), 0);
    chk({tag, "_acq_index"}, int'(acq_index), 0);
    chk({tag, "_count_max"}, int'(count_max), 0);
  endtask

  initial begin
    int n, cm, to, a, d, bc, rh, dh, last_cm;
    aresetn      = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    n_acq        = '0;
    count_max_in = '0;
    timeout      = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    aresetn = 1'b1;
    repeat (2) @(negedge clk);

    // Three acquisitions with a long generator busy phase.
    gen_stuck = 1'b0;
    gen_len   = 120;
    plan(3, 100, 0, 0);
    do_start(3, 100, 0);
    wait_idle(1000);
    last_cm = 100;
    repeat (2) @(negedge clk);

    // Random complete runs; a nonzero timeout sits just beyond the wait window.
    for (int i = 0; i < 4; i++) begin
      n       = int'($urandom_range(1, 4));
      cm      = int'($urandom_range(0, 8191));
      gen_len = int'($urandom_range(1, 20));
      to      = ($urandom_range(0, 1) == 0) ? 0 : gen_len + 2 + int'($urandom_range(0, 5));
      plan(n, cm, 0, 0);
      do_start(n, cm, to);
      wait_idle(2000);
      last_cm = cm;
      repeat (2) @(negedge clk);
    end

    // Start with zero acquisitions is ignored.
    n_acq        = '0;
    count_max_in = BW'(55);
    timeout      = '0;
    start        = 1'b1;
    bc = 0; rh = 0; dh = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bc++;
      if (restart) rh++;
      if (done) dh++;
    end
    chk("zero_n_busy", bc, 0);
    chk("zero_n_restart", rh, 0);
    chk("zero_n_done", dh, 0);
    chk("zero_n_cm_held", int'(count_max), last_cm);

    // Abort in the second WAIT_READY of a four-acquisition run.
    gen_len = 30;
    plan(4, 77, 1, 2);
    do_start(4, 77, 0);
    wait_restarts(1);
    repeat (10) @(negedge clk);
    pulse_abort();
    chk("abort_busy_next", int'(busy), 0);
    chk("abort_flag", int'(aborted), 1);
    chk("abort_idx", int'(acq_index), 1);
    rh = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (restart) rh++;
    end
    chk("abort_no_restart", rh, 0);

    // Random aborts anywhere before the chosen acquisition completes.
    for (int i = 0; i < 3; i++) begin
      n       = int'($urandom_range(2, 5));
      a       = int'($urandom_range(1, n));
      cm      = int'($urandom_range(0, 8191));
      gen_len = int'($urandom_range(3, 15));
      d       = int'($urandom_range(1, gen_len));
      plan(n, cm, 1, a);
      do_start(n, cm, 0);
      if (a > 1) wait_restarts(a - 1);
      repeat (d) @(negedge clk);
      pulse_abort();
      wait_idle(20);
      repeat (2) @(negedge clk);
    end

    // Timeout of 50 with ready stuck low: busy for exactly 50 wait cycles after the restart.
    gen_stuck = 1'b1;
    plan(2, 33, 2, 1);
    do_start(2, 33, 50);
    bc = 0;
    while (busy && bc < 1000) begin
      @(negedge clk);
      if (busy) bc++;
    end
    chk("timeout_cycles", bc, 50);
    chk("timeout_flag", int'(timed_out), 1);
    chk("timeout_no_done", int'(done), 0);
    repeat (5) @(negedge clk);

    // Zero timeout never expires.
    plan(1, 44, 1, 1);
    do_start(1, 44, 0);
    repeat (10000) @(negedge clk);
    chk("no_timeout_busy", int'(busy), 1);
    chk("no_timeout_flag", int'(timed_out), 0);
    pulse_abort();
    wait_idle(10);
    gen_stuck = 1'b0;
    repeat (2) @(negedge clk);

    // Abort lands on the final NEXT cycle: abort wins over completion.
    gen_len = 10;
    plan(2, 66, 1, 2);
    do_start(2, 66, 0);
    wait_restarts(1);
    repeat (gen_len + 2) @(negedge clk);
    pulse_abort();
    chk("abort_vs_done_done", int'(done), 0);
    chk("abort_vs_done_flag", int'(aborted), 1);
    chk("abort_vs_done_idx", int'(acq_index), 1);
    repeat (3) @(negedge clk);

    // Start while busy is ignored; latched length stays.
    gen_len = 8;
    plan(3, 200, 0, 0);
    do_start(3, 200, 0);
    wait_restarts(1);
    repeat (3) @(negedge clk);
    n_acq        = NW'(1);
    count_max_in = BW'(5);
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_cm", int'(count_max), 200);
    wait_idle(500);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-run, then a normal run.
    gen_len = 120;
    exp_rst_idx.push_back(0);
    exp_rst_cm.push_back(321);
    do_start(3, 321, 0);
    repeat (20) @(negedge clk);
    #2 aresetn = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    chk("rst_queue_restart", exp_rst_idx.size(), 0);
    chk("rst_queue_end", exp_end.size(), 0);
    aresetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);
    gen_len = 5;
    plan(2, 9, 0, 0);
    do_start(2, 9, 0);
    wait_idle(200);
    repeat (3) @(negedge clk);

    chk("final_restart_queue", exp_rst_idx.size(), 0);
    chk("final_end_queue", exp_end.size(), 0);
    chk("done_pulses", done_seen, exp_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
